// File: rtl/preamble_pkg.sv
// Shared types and default widths for the preamble detector.
package preamble_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_PREAMBLE_LEN = 8;
  localparam int DEF_LEN_WIDTH    = 16;
  localparam int STAT_WIDTH       = 16;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; accepts a new beat whenever it is
// empty or being drained in the same cycle.
module axis_out_reg
  import preamble_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  inValid,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inLast,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  assign inReady = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (inValid && inReady) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= inData;
      m_axis_tlast  <= inLast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/preamble_detect.sv
// Preamble matcher: consumes a PREAMBLE_LEN-word sync pattern, then forwards
// payload_len words. Optional stats counters under PREAMBLE_DETECT_STATS_EN.
module preamble_detect
  import preamble_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               enable,
  input  logic [DATA_WIDTH*PREAMBLE_LEN-1:0] pattern,
  input  logic [LEN_WIDTH-1:0]               payload_len,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               detect,
  output logic                               short_err
`ifdef PREAMBLE_DETECT_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]              det_count,
  output logic [STAT_WIDTH-1:0]              err_count
`endif
);

  localparam int CNT_W = $clog2(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PREAMBLE_LEN - 1);

  state_t                 state, stateNxt;
  logic [CNT_W-1:0]       matchCnt, matchNxt;
  logic [LEN_WIDTH-1:0]   remCnt, remNxt;
  logic                   detNxt, errNxt;
  logic                   rdyEn;
  logic                   outReady;
  logic                   wordXfer;
  logic                   lastWord;
  logic                   fwdValid, fwdLast;

  logic [PREAMBLE_LEN-1:0][DATA_WIDTH-1:0] patArr;
  assign patArr = pattern;

  // rdyEn holds off the upstream until the first edge after reset release
  assign s_axis_tready = rdyEn && ((state == SEARCH) || outReady);
  assign wordXfer      = s_axis_tvalid && s_axis_tready;
  assign lastWord      = (remCnt == LEN_WIDTH'(1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= SEARCH;
      matchCnt  <= '0;
      remCnt    <= '0;
      detect    <= 1'b0;
      short_err <= 1'b0;
      rdyEn     <= 1'b0;
    end else begin
      state     <= stateNxt;
      matchCnt  <= matchNxt;
      remCnt    <= remNxt;
      detect    <= detNxt;
      short_err <= errNxt;
      rdyEn     <= 1'b1;
    end
  end

  always_comb begin
    stateNxt = state;
    matchNxt = matchCnt;
    remNxt   = remCnt;
    detNxt   = 1'b0;
    errNxt   = 1'b0;
    fwdValid = 1'b0;
    fwdLast  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (!enable) begin
          matchNxt = '0;
        end else if (wordXfer) begin
          if (s_axis_tdata == patArr[matchCnt]) begin
            if (matchCnt == LAST_IDX) begin
              detNxt   = 1'b1;
              matchNxt = '0;
              remNxt   = payload_len;
              if (payload_len != '0) stateNxt = PAYLOAD;
            end else begin
              matchNxt = matchCnt + CNT_W'(1);
            end
          end else begin
            // a mismatching word may itself start a new preamble
            matchNxt = (s_axis_tdata == patArr[0]) ? CNT_W'(1) : '0;
          end
        end
      end
      PAYLOAD: begin
        if (wordXfer) begin
          fwdValid = 1'b1;
          fwdLast  = lastWord || s_axis_tlast;
          remNxt   = fwdLast ? '0 : remCnt - LEN_WIDTH'(1);
          errNxt   = s_axis_tlast && !lastWord;
          if (fwdLast) stateNxt = SEARCH;
        end
      end
      default: stateNxt = SEARCH;
    endcase
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outReg (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .inValid      (fwdValid),
    .inData       (s_axis_tdata),
    .inLast       (fwdLast),
    .inReady      (outReady),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

`ifdef PREAMBLE_DETECT_STATS_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      det_count <= '0;
      err_count <= '0;
    end else begin
      if (detect && (det_count != '1))    det_count <= det_count + STAT_WIDTH'(1);
      if (short_err && (err_count != '1)) err_count <= err_count + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_preamble_detect.sv
// Scoreboard bench for preamble_detect: stimulus pushes expected beats, a
// monitor pops and compares them and checks hold-under-backpressure.
module tb_preamble_detect;

  localparam int DW = 32;
  localparam int PL = 8;
  localparam int LW = 16;

  logic              tb_ACLK = 1'b0;
  logic              ARESETN;
  logic              enable;
  logic [DW*PL-1:0]  pattern;
  logic [LW-1:0]     payload_len;
  logic [DW-1:0]     s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              detect;
  logic              short_err;
`ifdef PREAMBLE_DETECT_STATS_EN
  logic [15:0]       det_count;
  logic [15:0]       err_count;
`endif

  always #5 tb_ACLK = ~tb_ACLK;

  preamble_detect #(
    .DATA_WIDTH(DW), .PREAMBLE_LEN(PL), .LEN_WIDTH(LW)
  ) dut (
    .ACLK         (tb_ACLK),
    .ARESETN      (ARESETN),
    .enable       (enable),
    .pattern      (pattern),
    .payload_len  (payload_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .detect       (detect),
    .short_err    (short_err)
`ifdef PREAMBLE_DETECT_STATS_EN
    ,
    .det_count    (det_count),
    .err_count    (err_count)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t expQ[$];
  int tests = 0, fails = 0;
  int expDet = 0, expErr = 0, detObs = 0, errObs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: samples mid-low-phase, after the stimulus has settled
  logic          stallPrev = 1'b0;
  logic [DW-1:0] holdData;
  logic          holdLast;
  always begin
    beat_t e;
    @(negedge tb_ACLK);
    #2;
    if (ARESETN) begin
      if (detect)    detObs++;
      if (short_err) errObs++;
      if (stallPrev) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data",  64'(m_axis_tdata),  64'(holdData));
        chk("hold_last",  64'(m_axis_tlast),  64'(holdLast));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          e = expQ.pop_front();
          chk("out_data", 64'(m_axis_tdata), 64'(e.data));
          chk("out_last", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      stallPrev = m_axis_tvalid && !m_axis_tready;
      holdData  = m_axis_tdata;
      holdLast  = m_axis_tlast;
    end else begin
      stallPrev = 1'b0;
    end
  end

  // called at a negedge; returns at the negedge after the transfer edge
  task automatic sendWord(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    #1;
    while (!s_axis_tready && guard < 50) begin
      @(negedge tb_ACLK);
      #1;
      guard++;
    end
    if (!s_axis_tready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word 0x%0h never accepted", d);
    end else begin
      @(posedge tb_ACLK);
    end
    @(negedge tb_ACLK);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic sendPre();
    for (int k = 0; k < PL; k++) sendWord(DW'(k + 1), 1'b0);
  endtask

  task automatic sendPay(input logic [DW-1:0] base, input int n, input int lastAt);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{data: base + DW'(i), last: (i == lastAt)});
      sendWord(base + DW'(i), 1'b0);
    end
  endtask

  task automatic settle(input string nm);
    repeat (4) @(negedge tb_ACLK);
    #1;
    chk({nm, "_detect"},    64'(detObs), 64'(expDet));
    chk({nm, "_short_err"}, 64'(errObs), 64'(expErr));
    chk({nm, "_drained"},   64'(expQ.size()), 64'd0);
    @(negedge tb_ACLK);
  endtask

  initial begin
    ARESETN       = 1'b0;
    enable        = 1'b1;
    payload_len   = LW'(4);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < PL; k++) pattern[k*DW +: DW] = DW'(k + 1);

    repeat (2) @(negedge tb_ACLK);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_detect", 64'(detect),        64'd0);
    chk("rst_serr",   64'(short_err),     64'd0);
    chk("rst_ready",  64'(s_axis_tready), 64'd0);
    @(negedge tb_ACLK);
    ARESETN = 1'b1;
    #1;
    chk("ready_before_edge", 64'(s_axis_tready), 64'd0);
    @(negedge tb_ACLK);
    #1;
    chk("ready_after_edge", 64'(s_axis_tready), 64'd1);
    @(negedge tb_ACLK);

    // basic match; tlast inside preamble is ignored, payload_len change mid-payload too
    for (int k = 0; k < PL; k++) sendWord(DW'(k + 1), k == 3);
    expDet++;
    payload_len = LW'(1);
    sendPay(32'hA0, 4, 3);
    settle("basic");

    // restart after mismatch; enable drop during payload does not cut it short
    payload_len = LW'(2);
    sendWord(32'h01, 1'b0);
    sendWord(32'h02, 1'b0);
    sendPre();
    expDet++;
    enable = 1'b0;
    sendPay(32'hB0, 2, 1);
    enable = 1'b1;
    settle("restart");

    // backpressure: three stalled cycles mid-payload
    payload_len = LW'(4);
    sendPre();
    expDet++;
    sendPay(32'hC0, 2, -1);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hC2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 64'(s_axis_tready), 64'd0);
      @(negedge tb_ACLK);
    end
    m_axis_tready = 1'b1;
    expQ.push_back('{data: 32'hC2, last: 1'b0});
    sendWord(32'hC2, 1'b0);
    expQ.push_back('{data: 32'hC3, last: 1'b1});
    sendWord(32'hC3, 1'b0);
    settle("backpressure");

    // early tlast on third payload word, then a stray word is dropped
    payload_len = LW'(6);
    sendPre();
    expDet++;
    sendPay(32'hD0, 2, -1);
    expQ.push_back('{data: 32'hD2, last: 1'b1});
    sendWord(32'hD2, 1'b1);
    expErr++;
    sendWord(32'hD3, 1'b0);
    settle("early_tlast");

    // zero-length payload: detect only, nothing forwarded
    payload_len = LW'(0);
    sendPre();
    expDet++;
    sendWord(32'hE0, 1'b0);
    settle("zero_len");

    // enable low clears partial progress
    payload_len = LW'(2);
    for (int k = 0; k < 4; k++) sendWord(DW'(k + 1), 1'b0);
    enable = 1'b0;
    for (int k = 4; k < PL; k++) sendWord(DW'(k + 1), 1'b0);
    enable = 1'b1;
    for (int k = 4; k < PL; k++) sendWord(DW'(k + 1), 1'b0);
    settle("enable_low");

    // reset mid-payload with a beat parked in the output register
    payload_len   = LW'(4);
    sendPre();
    expDet++;
    m_axis_tready = 1'b0;
    sendWord(32'h77, 1'b0);
    ARESETN = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("midrst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("midrst_ready",  64'(s_axis_tready), 64'd0);
    chk("midrst_detect", 64'(detect),        64'd0);
    chk("midrst_serr",   64'(short_err),     64'd0);
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rerelease_ready", 64'(s_axis_tready), 64'd0);
    @(negedge tb_ACLK);
    m_axis_tready = 1'b1;
    payload_len   = LW'(2);
    sendPre();
    expDet++;
    sendPay(32'hF0, 2, 1);
    settle("after_reset");
`ifdef PREAMBLE_DETECT_STATS_EN
    chk("det_count", 64'(det_count), 64'd1);
    chk("err_count", 64'(err_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/preamble_detect.md
PREAMBLE_DETECT -- requirements
Module: preamble_detect

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream word width in bits.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 8, number of preamble words matched (2..16).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the payload length field.
REQ-004 SHALL have port ACLK, input, 1, the only clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, detection enable from the register bank.
REQ-007 SHALL have port pattern, input, DATA_WIDTH*PREAMBLE_LEN, expected preamble; word k in bits [k*DATA_WIDTH +: DATA_WIDTH], word 0 first.
REQ-008 SHALL have port payload_len, input, LEN_WIDTH, payload words forwarded per detection.
REQ-009 SHALL have ports s_axis_tdata (DATA_WIDTH), s_axis_tlast (1), s_axis_tvalid (1) as inputs and s_axis_tready (1) as output: the upstream preamble/payload stream.
REQ-010 SHALL have ports m_axis_tdata (DATA_WIDTH), m_axis_tlast (1), m_axis_tvalid (1) as outputs and m_axis_tready (1) as input: the payload stream.
REQ-011 SHALL have outputs detect (1), a one-cycle pulse per preamble match, and short_err (1), a one-cycle pulse on early s_axis_tlast.

Function
REQ-012 SHALL implement states SEARCH and PAYLOAD. An input word transfers when s_axis_tvalid and s_axis_tready are both high.
REQ-013 SHALL hold s_axis_tready high in SEARCH. Preamble words are consumed and never forwarded.
REQ-014 SHALL, in SEARCH with enable high, compare each transferred word against pattern[match_cnt].
- On equal: match_cnt increments.
- On unequal: match_cnt becomes 1 if the word equals pattern[0], else 0.
REQ-015 SHALL, when the transfer completing word PREAMBLE_LEN-1 matches:
- pulse detect the following cycle;
- latch payload_len into rem_cnt;
- clear match_cnt;
- enter PAYLOAD, or stay in SEARCH if the latched payload_len is 0.
REQ-016 SHALL, in SEARCH with enable low, accept and discard words and hold match_cnt at 0.
REQ-017 SHALL, in PAYLOAD, pass each transferred word to a single output register with one-cycle latency.
- s_axis_tready = !m_axis_tvalid || m_axis_tready.
- Full throughput is one word per cycle.
REQ-018 SHALL decrement rem_cnt per forwarded word and set m_axis_tlast on the word where rem_cnt reaches 0, then return to SEARCH.
REQ-019 SHALL, if s_axis_tlast arrives in PAYLOAD before the final word:
- forward that word with m_axis_tlast high;
- pulse short_err;
- return to SEARCH.
REQ-020 SHALL ignore s_axis_tlast in SEARCH.
REQ-021 SHALL keep m_axis_tdata and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-022 SHALL let a deassertion of enable in PAYLOAD take effect only after the current payload completes.
REQ-023 SHALL leave the current payload unaffected by changes to pattern or payload_len during PAYLOAD.

Reset
REQ-024 SHALL, on ARESETN low, asynchronously force:
- state to SEARCH;
- match_cnt and rem_cnt to 0;
- m_axis_tvalid, m_axis_tlast, m_axis_tdata, detect, short_err to 0;
- s_axis_tready to 0.
REQ-025 SHALL raise s_axis_tready no earlier than the first ACLK edge after ARESETN rises. Reset in the middle of a payload discards the payload with no tlast emitted.

Configuration
REQ-026 SHALL, when PREAMBLE_DETECT_STATS_EN is defined:
- add outputs det_count (16) and err_count (16);
- det_count counts detect pulses and err_count counts short_err pulses;
- both counters saturate at 0xFFFF and reset to 0.
When the macro is undefined, these ports and counters SHALL NOT exist and all other behaviour is identical.

Structure
REQ-027 SHALL place the state enumeration and the default-width constants in the shared package preamble_pkg.
REQ-028 SHALL implement the output register and handshake as sub-module axis_out_reg. The FSM, matcher and counters stay in preamble_detect.

Verification
REQ-029 SHALL verify the basic match:
- Stimulus: pattern 0x01..0x08, payload_len=4, input stream 0x01..0x08 then 0xA0..0xA3.
- Response: one detect pulse; output 0xA0..0xA3 with tlast on 0xA3.
REQ-030 SHALL verify restart after a mismatch:
- Stimulus: input 0x01,0x02,0x01,0x02..0x08, then 2 payload words.
- Response: exactly one detect and 2 forwarded words.
REQ-031 SHALL verify backpressure:
- Stimulus: m_axis_tready low for 3 cycles mid-payload.
- Response: data held stable, no loss, no duplication, s_axis_tready low while the output register is full.
REQ-032 SHALL verify early tlast:
- Stimulus: payload_len=6, s_axis_tlast on payload word 3.
- Response: 3 words out, tlast on the 3rd, short_err pulse, return to SEARCH.
REQ-033 SHALL verify payload_len=0:
- Stimulus: payload_len=0, input 0x01..0x08.
- Response: detect pulse, m_axis_tvalid stays low.
REQ-034 SHALL verify reset mid-payload:
- Stimulus: ARESETN low mid-payload, then a fresh preamble.
- Response: all outputs 0 during reset; detection resumes normally.
- With PREAMBLE_DETECT_STATS_EN defined, det_count equals 1 after the fresh preamble.
